// File: rtl/scan_chain_pkg.sv
// ============================================================================
// Module   : scan_chain_pkg
// Purpose  : Shared state encoding for the scan chain controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package scan_chain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_piso_sipo.sv
// ============================================================================
// Module   : scan_piso_sipo
// Purpose  : Pattern PISO (MSB first) and response SIPO for the scan driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_piso_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_pat,
  input  logic [WIDTH-1:0] pattern,
  input  logic             shift_pat,
  input  logic             shift_resp,
  input  logic             latch_resp,
  input  logic             serial_in,
  output logic             pat_msb,
  output logic [WIDTH-1:0] response
);

  logic [WIDTH-1:0] r_pat_reg;
  logic [WIDTH-1:0] r_resp_sh;
  logic [WIDTH-1:0] r_response;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_reg  <= '0;
      r_resp_sh  <= '0;
      r_response <= '0;
    end else begin
      if (load_pat) begin
        r_pat_reg <= pattern;
      end else if (shift_pat) begin
        r_pat_reg <= {r_pat_reg[WIDTH-2:0], 1'b0};
      end

      if (shift_resp) begin
        r_resp_sh <= {r_resp_sh[WIDTH-2:0], serial_in};
      end

      // The final serial bit arrives on the same edge, so fold it in directly.
      if (latch_resp) begin
        r_response <= {r_resp_sh[WIDTH-2:0], serial_in};
      end
    end
  end

  assign pat_msb  = r_pat_reg[WIDTH-1];
  assign response = r_response;

endmodule

`default_nettype wire

// File: rtl/scan_chain_controller.sv
// ============================================================================
// Module   : scan_chain_controller
// Purpose  : Load / capture / unload sequencer for an attached scan chain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_chain_controller
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 chain_sout,
  output logic                 scan_test,
  output logic                 scan_sin,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 busy,
  output logic                 done
);

  localparam int c_cnt_w = $clog2(CHAIN_LEN);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CHAIN_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  scan_state_t        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_scan_test;
  logic               r_busy;
  logic               r_done;

  logic w_accept;
  logic w_shift_pat;
  logic w_shift_resp;
  logic w_latch_resp;
  logic w_pat_msb;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_shift_pat  = (r_state == LOAD);
  assign w_shift_resp = (r_state == UNLOAD);
  assign w_latch_resp = (r_state == UNLOAD) && (r_cnt == c_cnt_last);

  // Outputs are registered alongside the state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_scan_test <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_scan_test <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (r_cnt == c_cnt_last) begin
            r_state     <= CAPTURE;
            r_cnt       <= '0;
            r_scan_test <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        CAPTURE: begin
          r_state     <= UNLOAD;
          r_scan_test <= 1'b1;
        end
        UNLOAD: begin
          if (r_cnt == c_cnt_last) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            r_scan_test <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_scan_test <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  scan_piso_sipo #(
    .WIDTH(CHAIN_LEN)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_pat  (w_accept),
    .pattern   (pattern),
    .shift_pat (w_shift_pat),
    .shift_resp(w_shift_resp),
    .latch_resp(w_latch_resp),
    .serial_in (chain_sout),
    .pat_msb   (w_pat_msb),
    .response  (response)
  );

  assign scan_test = r_scan_test;
  assign scan_sin  = (r_state == LOAD) && w_pat_msb;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_controller.sv
// ============================================================================
// Module   : tb_scan_chain_controller
// Purpose  : Directed bench with an 8-bit scannable chain model attached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scan_chain_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic       chain_sout;
  logic       scan_test;
  logic       scan_sin;
  logic [7:0] response;
  logic       busy;
  logic       done;

  logic [7:0] chain_q;
  logic       d_inv;

  int errors = 0;
  int checks = 0;

  scan_chain_controller #(
    .CHAIN_LEN(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .chain_sout(chain_sout),
    .scan_test (scan_test),
    .scan_sin  (scan_sin),
    .response  (response),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scannable chain: functional d is either q or ~q.
  always_ff @(posedge clk) begin
    if (scan_test) chain_q <= {chain_q[6:0], scan_sin};
    else           chain_q <= d_inv ? ~chain_q : chain_q;
  end
  assign chain_sout = chain_q[7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; returns in the cycle after DONE.
  task automatic run_op(input logic [7:0] pat, input logic inv, input logic [7:0] exp, input string tag);
    int lat;
    int busy_cnt;
    d_inv   = inv;
    pattern = pat;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    pattern = ~pat;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      busy_cnt += int'(busy);
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 18);
    check({tag, " response"}, 32'(response), 32'(exp));
    check({tag, " busy_cycles"}, busy_cnt, 17);
    tick();
    check({tag, " done_clears"}, 32'(done), 0);
    check({tag, " response_holds"}, 32'(response), 32'(exp));
  endtask

  initial begin
    logic [7:0] a5;
    int lat;
    int n_done;
    int last_done;
    int first_done;

    reset   = 1'b1;
    start   = 1'b0;
    pattern = 8'h00;
    d_inv   = 1'b0;
    chain_q = 8'h00;
    tick();
    tick();
    check("reset scan_test", 32'(scan_test), 0);
    check("reset scan_sin", 32'(scan_sin), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset response", 32'(response), 0);
    reset = 1'b0;
    tick();

    // Load order and round trip with d = ~q.
    a5      = 8'hA5;
    d_inv   = 1'b1;
    pattern = a5;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    pattern = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("load sin[%0d]", k), 32'(scan_sin), 32'(a5[7-k]));
      check($sformatf("load test[%0d]", k), 32'(scan_test), 1);
      tick();
    end
    check("capture chain", 32'(chain_q), 32'h A5);
    check("capture test", 32'(scan_test), 0);
    check("capture busy", 32'(busy), 1);
    lat = 9;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("roundtrip latency", lat, 18);
    check("roundtrip response", 32'(response), 32'h5A);
    check("roundtrip busy", 32'(busy), 0);
    tick();

    run_op(8'h00, 1'b0, 8'h00, "corner00");
    run_op(8'hFF, 1'b0, 8'hFF, "cornerFF");
    run_op(8'h01, 1'b0, 8'h01, "corner01");

    // start pulses during busy (cycle 5) and DONE (cycle 18) are ignored.
    d_inv   = 1'b0;
    pattern = 8'h96;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        n_done++;
        check("ignore done_cycle", c, 18);
        check("ignore response", 32'(response), 32'h96);
      end
      start   = (c == 5 || c == 18);
      pattern = start ? 8'hFF : pattern;
      tick();
    end
    start = 1'b0;
    check("ignore done_count", n_done, 1);
    check("ignore response_end", 32'(response), 32'h96);

    // Reset asserted in cycle 4 of LOAD.
    pattern = 8'hC3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midreset busy", 32'(busy), 0);
    check("midreset scan_test", 32'(scan_test), 0);
    check("midreset response", 32'(response), 0);
    check("midreset done", 32'(done), 0);
    tick();
    reset = 1'b0;
    tick();
    run_op(8'h3C, 1'b0, 8'h3C, "after_reset");

    // Back-to-back with start held high.
    d_inv      = 1'b0;
    pattern    = 8'h5C;
    start      = 1'b1;
    tick();
    n_done     = 0;
    last_done  = -100;
    first_done = -100;
    for (int c = 1; c <= 70; c++) begin
      if (c == last_done + 1) check("b2b idle_busy", 32'(busy), 0);
      if (c == last_done + 2) check("b2b restart_busy", 32'(busy), 1);
      if (done) begin
        if (n_done == 0) begin
          first_done = c;
          check("b2b first_done", c, 18);
        end else begin
          check("b2b period", c - last_done, 19);
        end
        check("b2b done_busy", 32'(busy), 0);
        check("b2b response", 32'(response), 32'h5C);
        n_done++;
        last_done = c;
      end
      tick();
    end
    start = 1'b0;
    check("b2b done_count", n_done, 3);
    check("b2b last_done", last_done - first_done, 38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_chain_controller.md
# scan_chain_controller

Tester-side driver for a scannable register chain: it produces the `test`/`sin` controls the chain consumes and collects the chain's `sout`. One operation per `start`:
- shift a latched pattern into the chain;
- pulse one functional capture cycle;
- shift the captured state out into `response`.

It sits between the on-chip test/BIST sequencer and any CHAIN_LEN-bit scan chain clocked on the same `clk`.

## Interface
- CHAIN_LEN, default 8: number of flops in the attached chain. Must be ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request an operation; sampled only in IDLE.
- pattern  input  CHAIN_LEN  vector to load into the chain; latched when `start` is accepted.
- chain_sout  input  1  serial output of the chain (chain MSB).
- scan_test  output  1  drives the chain's `test`: 1 = shift, 0 = functional capture/load.
- scan_sin  output  1  drives the chain's `sin`.
- response  output  CHAIN_LEN  chain contents captured in the CAPTURE cycle; valid from `done` until the next `done`.
- busy  output  1  high in LOAD, CAPTURE and UNLOAD.
- done  output  1  one-cycle pulse at completion.

## Operation
- Chain contract:
  - while `test` = 1, the chain does q <= {q[N-2:0], sin} and `sout` = q[N-1];
  - while `test` = 0, the chain does q <= d.
- FSM states are IDLE, LOAD, CAPTURE, UNLOAD and DONE.
- IDLE:
  - `scan_test` = 0 and `scan_sin` = 0.
  - On `start` = 1: `pat_reg` <= `pattern`, `cnt` <= 0, go to LOAD.
- LOAD, CHAIN_LEN cycles (k = 0..N-1):
  - `scan_test` = 1 and `scan_sin` = `pat_reg[N-1-k]`, so the MSB goes first.
  - After cycle N-1, go to CAPTURE. The chain then holds `pattern`.
- CAPTURE, 1 cycle: `scan_test` = 0, and the chain loads its functional d.
- UNLOAD, CHAIN_LEN cycles:
  - `scan_test` = 1 and `scan_sin` = 0.
  - On each rising edge, `resp_sh` <= {`resp_sh[N-2:0]`, `chain_sout`}.
  - After cycle N-1, go to DONE.
- DONE, 1 cycle:
  - `done` = 1, `busy` = 0, and `response` is updated from `resp_sh`.
  - Go to IDLE next cycle.
- `start` outside IDLE is ignored; this includes DONE.
- `pattern` changes after acceptance have no effect.
- `cnt` width is $clog2(CHAIN_LEN). `cnt` wraps to 0 on each LOAD→CAPTURE and UNLOAD→DONE transition.

## Timing
- All outputs are Moore decodes of registered state, `cnt` and `pat_reg`. There is no combinational path from `start` or `chain_sout` to any output.
- Values on reset: state IDLE; `scan_test`, `scan_sin`, `busy` and `done` = 0; `response` = 0.
- Cycle sequence, with `start` accepted at edge E0:
  - LOAD occupies cycles 1..N;
  - CAPTURE occupies cycle N+1;
  - UNLOAD occupies cycles N+2..2N+1;
  - `done` is high in cycle 2N+2;
  - the earliest next acceptance is the edge ending cycle 2N+3 (in IDLE).
- `busy` is high for exactly 2N+1 cycles per operation.
- `response` changes only on the edge entering DONE. It is stable for the whole DONE cycle and holds its value afterwards.
- Reset asserted mid-operation: immediate return to IDLE with `scan_test` = 0, no `done` pulse, and `response` cleared. The chain contents are then undefined for the bench.

## Structure
- Package `scan_chain_pkg`: the `scan_state_t` enum (IDLE, LOAD, CAPTURE, UNLOAD, DONE).
- Sub-module `scan_piso_sipo`: a parameterised shift register pair.
  - Holds `pat_reg`, which shifts toward its MSB on LOAD.
  - Holds `resp_sh`, which accepts serial input on UNLOAD.
  - The FSM and counter stay in the top module.

## Test plan
Each bench attaches an 8-bit scannable chain (N = 8).
- Load order: `pattern` = 8'hA5 → `scan_sin` during LOAD = 1,0,1,0,0,1,0,1; the chain holds 8'hA5 in the CAPTURE cycle.
- Round trip: chain d = ~q, `pattern` = 8'hA5 → `response` = 8'h5A when `done` = 1, 18 cycles after acceptance.
- Corner patterns: d = q, patterns 8'h00, then 8'hFF, then 8'h01 → `response` = 8'h00, 8'hFF, 8'h01 respectively.
- `start` during busy or DONE: pulse `start` at cycles 5 and 18 with `pattern` = 8'hFF → exactly one `done`; `response` reflects the first pattern only.
- Reset mid-LOAD: assert `reset` at cycle 4 → `busy` = 0, `scan_test` = 0 and `response` = 0 within the same cycle; a following `start` with 8'h3C and d = q → `response` = 8'h3C.
- Back-to-back: hold `start` high continuously → `done` pulses every 19 cycles; `busy` is low for exactly 2 cycles (DONE and IDLE) between operations.
